// File: rtl/loader_pkg.sv
// -----------------------------------------------------------------------------
// loader_pkg
// Shared definitions for the byte-stream instruction loader:
//   - state_e           : loader FSM state encoding
//   - BYTES_PER_WORD    : bytes assembled into one instruction word
//   - MAX_WORDS_DEFAULT : default word capacity of the instruction memory
// -----------------------------------------------------------------------------
package loader_pkg;

  localparam int BYTES_PER_WORD    = 4;
  localparam int MAX_WORDS_DEFAULT = 10;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    DATA,
    WRITE,
    CSUM,
    DONE,
    ERR
  } state_e;

endpackage

// File: rtl/instr_loader_word_assembler.sv
// -----------------------------------------------------------------------------
// word_assembler
// Packs stream bytes MSB-first into a 32-bit word and keeps a running XOR of
// every byte shifted in.
// Ports:
//   clk, reset    : clock, asynchronous active-low reset
//   clear_i       : zero the byte index, word register and checksum
//   shift_i       : accept byte_i into the word and the checksum
//   byte_i        : incoming stream byte
//   word_full_o   : the byte being shifted this cycle completes a word
//   word_next_o   : word value including byte_i (valid while word_full_o)
//   csum_o        : XOR of all bytes shifted since the last clear
// -----------------------------------------------------------------------------
module word_assembler
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear_i,
  input  logic        shift_i,
  input  logic [7:0]  byte_i,
  output logic        word_full_o,
  output logic [31:0] word_next_o,
  output logic [7:0]  csum_o
);

  localparam int IDX_W = $clog2(BYTES_PER_WORD);

  logic [IDX_W-1:0] byte_idx_q, byte_idx_d;
  logic [31:0]      word_q, word_d;
  logic [7:0]       csum_q, csum_d;

  // The completed word is presented combinationally so the top can register
  // it into wr_data on the same edge that accepts the last byte.
  assign word_next_o = {word_q[23:0], byte_i};
  assign word_full_o = shift_i && (byte_idx_q == IDX_W'(BYTES_PER_WORD - 1));
  assign csum_o      = csum_q;

  always_comb begin
    // NOTE: every variable gets a default first, so no path leaves it
    // unassigned and no latch is inferred.
    byte_idx_d = byte_idx_q;
    word_d     = word_q;
    csum_d     = csum_q;
    if (clear_i) begin
      byte_idx_d = '0;
      word_d     = '0;
      csum_d     = '0;
    end else if (shift_i) begin
      byte_idx_d = byte_idx_q + 1'b1;   // wraps modulo BYTES_PER_WORD
      word_d     = word_next_o;
      csum_d     = csum_q ^ byte_i;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!reset) begin
      byte_idx_q <= '0;
      word_q     <= '0;
      csum_q     <= '0;
    end else begin
      byte_idx_q <= byte_idx_d;
      word_q     <= word_d;
      csum_q     <= csum_d;
    end
  end

endmodule

// File: rtl/instr_loader.sv
// -----------------------------------------------------------------------------
// instr_loader
// Boot loader: receives a framed byte stream (count N, 4*N data bytes MSB
// first, XOR checksum), writes each assembled word into the instruction
// memory and releases the CPU only after a frame with a good checksum.
// Ports:
//   clk, reset  : clock, asynchronous active-low reset
//   in_data     : stream byte            in_valid : in_data valid
//   in_ready    : loader accepts a byte (transfer when in_valid && in_ready)
//   start       : re-arm pulse, honoured only in DONE or ERR
//   wr_en       : one-cycle memory write strobe
//   wr_addr     : byte address of the word (multiple of 4)
//   wr_data     : word, [31:24] at wr_addr, [7:0] at wr_addr+3
//   cpu_hold    : 1 keeps the CPU and PC in reset
//   load_done   : frame loaded with a good checksum
//   load_err    : frame rejected (oversize or bad checksum)
// All outputs are registered; their next values are decoded from the next
// state so they line up with the state register.
// -----------------------------------------------------------------------------
module instr_loader
  import loader_pkg::*;
#(
  parameter int MAX_WORDS = MAX_WORDS_DEFAULT,
  parameter int AW        = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [7:0]    in_data,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          start,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [31:0]   wr_data,
  output logic          cpu_hold,
  output logic          load_done,
  output logic          load_err
);

  localparam logic [7:0] MAX_N = 8'(MAX_WORDS);

  state_e        state_q, state_d;
  logic [7:0]    n_q, n_d;
  logic [7:0]    word_idx_q, word_idx_d;

  logic          in_ready_q, in_ready_d;
  logic          wr_en_q, wr_en_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [31:0]   wr_data_q, wr_data_d;
  logic          cpu_hold_q, cpu_hold_d;
  logic          load_done_q, load_done_d;
  logic          load_err_q, load_err_d;

  logic          transfer;
  logic          asm_clear, asm_shift;
  logic          word_full;
  logic [31:0]   word_next;
  logic [7:0]    csum;

  assign transfer = in_valid && in_ready_q;

  word_assembler u_asm (
    .clk         (clk),
    .reset       (reset),
    .clear_i     (asm_clear),
    .shift_i     (asm_shift),
    .byte_i      (in_data),
    .word_full_o (word_full),
    .word_next_o (word_next),
    .csum_o      (csum)
  );

  // State register (with the frame counters and registered outputs).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      n_q         <= '0;
      word_idx_q  <= '0;
      in_ready_q  <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      cpu_hold_q  <= 1'b1;
      load_done_q <= 1'b0;
      load_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      word_idx_q  <= word_idx_d;
      in_ready_q  <= in_ready_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      cpu_hold_q  <= cpu_hold_d;
      load_done_q <= load_done_d;
      load_err_q  <= load_err_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    word_idx_d = word_idx_q;
    asm_clear  = 1'b0;
    asm_shift  = 1'b0;
    unique case (state_q)
      IDLE: state_d = HDR;
      HDR: begin
        if (transfer) begin
          n_d        = in_data;
          word_idx_d = '0;
          asm_clear  = 1'b1;
          if (in_data > MAX_N)        state_d = ERR;
          else if (in_data == 8'd0)   state_d = CSUM;
          else                        state_d = DATA;
        end
      end
      DATA: begin
        if (transfer) begin
          asm_shift = 1'b1;
          if (word_full) state_d = WRITE;
        end
      end
      WRITE: begin
        word_idx_d = word_idx_q + 8'd1;
        state_d    = (word_idx_q + 8'd1 == n_q) ? CSUM : DATA;
      end
      CSUM: begin
        // The checksum byte itself is compared, never accumulated.
        if (transfer) state_d = (in_data == csum) ? DONE : ERR;
      end
      DONE, ERR: begin
        if (start) state_d = HDR;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output decode from the next state, registered in the state process.
  always_comb begin
    in_ready_d  = (state_d == HDR) || (state_d == DATA) || (state_d == CSUM);
    wr_en_d     = (state_d == WRITE);
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    cpu_hold_d  = (state_d != DONE);
    load_done_d = (state_d == DONE);
    load_err_d  = (state_d == ERR);
    if (state_d == WRITE) begin
      // word_idx_q still holds the index of the word being completed.
      wr_addr_d = AW'({word_idx_q, 2'b00});
      wr_data_d = word_next;
    end
  end

  assign in_ready  = in_ready_q;
  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign cpu_hold  = cpu_hold_q;
  assign load_done = load_done_q;
  assign load_err  = load_err_q;

endmodule

// File: tb/tb_instr_loader.sv
// -----------------------------------------------------------------------------
// tb_instr_loader
// Directed bench for instr_loader: drives inputs on the falling edge, samples
// outputs on the falling edge, and logs every write strobe seen.
// -----------------------------------------------------------------------------
module tb_instr_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        start = 1'b0;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        cpu_hold;
  logic        load_done;
  logic        load_err;

  int checks = 0;
  int errors = 0;

  // Write log filled by the monitor only.
  int          wr_cnt = 0;
  int          ready_in_write = 0;
  logic [31:0] wr_addr_log [0:63];
  logic [31:0] wr_data_log [0:63];

  always #5 clk = ~clk;

  instr_loader #(.MAX_WORDS(10), .AW(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .start     (start),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .cpu_hold  (cpu_hold),
    .load_done (load_done),
    .load_err  (load_err)
  );

  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      if (wr_cnt < 64) begin
        wr_addr_log[wr_cnt] = wr_addr;
        wr_data_log[wr_cnt] = wr_data;
      end
      wr_cnt = wr_cnt + 1;
      if (in_ready !== 1'b0) ready_in_write = ready_in_write + 1;
    end
  end

  // Offer one byte from a falling edge; return on the falling edge after it
  // was accepted, with in_valid low.
  task automatic send_byte(input logic [7:0] b);
    int waited = 0;
    in_data  = b;
    in_valid = 1'b1;
    while (in_ready !== 1'b1 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (in_ready !== 1'b1) begin
      checks++; errors++;
      $display("FAIL send_timeout: in_ready=%0b, byte %02h never accepted", in_ready, b);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_std_frame(input logic [7:0] csum_byte);
    logic [7:0] f [10] = '{8'h02, 8'h8C, 8'h01, 8'h00, 8'h00,
                           8'h8C, 8'h02, 8'h00, 8'h01, 8'h00};
    for (int i = 0; i < 9; i++) send_byte(f[i]);
    send_byte(csum_byte);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++; if (in_ready  !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %0b exp 0", in_ready); end
    checks++; if (wr_en     !== 1'b0) begin errors++; $display("FAIL rst_wr_en: got %0b exp 0", wr_en); end
    checks++; if (wr_addr   !== 32'h0) begin errors++; $display("FAIL rst_wr_addr: got %08h exp 0", wr_addr); end
    checks++; if (wr_data   !== 32'h0) begin errors++; $display("FAIL rst_wr_data: got %08h exp 0", wr_data); end
    checks++; if (cpu_hold  !== 1'b1) begin errors++; $display("FAIL rst_cpu_hold: got %0b exp 1", cpu_hold); end
    checks++; if (load_done !== 1'b0) begin errors++; $display("FAIL rst_load_done: got %0b exp 0", load_done); end
    checks++; if (load_err  !== 1'b0) begin errors++; $display("FAIL rst_load_err: got %0b exp 0", load_err); end
    reset = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL idle_in_ready: got %0b exp 0", in_ready); end
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL hdr_in_ready: got %0b exp 1", in_ready); end
    checks++; if (cpu_hold !== 1'b1) begin errors++; $display("FAIL hdr_cpu_hold: got %0b exp 1", cpu_hold); end
  endtask

  task automatic test_normal();
    int base = wr_cnt;
    int rw   = ready_in_write;
    send_std_frame(8'h02);
    checks++; if (load_done !== 1'b1) begin errors++; $display("FAIL norm_done: got %0b exp 1", load_done); end
    checks++; if (cpu_hold  !== 1'b0) begin errors++; $display("FAIL norm_cpu_hold: got %0b exp 0", cpu_hold); end
    checks++; if (load_err  !== 1'b0) begin errors++; $display("FAIL norm_err: got %0b exp 0", load_err); end
    checks++; if (wr_cnt - base !== 2) begin errors++; $display("FAIL norm_wr_count: got %0d exp 2", wr_cnt - base); end
    checks++; if (wr_addr_log[base] !== 32'h0) begin errors++; $display("FAIL norm_addr0: got %08h exp 00000000", wr_addr_log[base]); end
    checks++; if (wr_data_log[base] !== 32'h8C010000) begin errors++; $display("FAIL norm_data0: got %08h exp 8C010000", wr_data_log[base]); end
    checks++; if (wr_addr_log[base+1] !== 32'h4) begin errors++; $display("FAIL norm_addr1: got %08h exp 00000004", wr_addr_log[base+1]); end
    checks++; if (wr_data_log[base+1] !== 32'h8C020001) begin errors++; $display("FAIL norm_data1: got %08h exp 8C020001", wr_data_log[base+1]); end
    checks++; if (ready_in_write !== rw) begin errors++; $display("FAIL norm_ready_in_write: got %0d cycles exp 0", ready_in_write - rw); end
    // Bytes offered while DONE are not consumed.
    in_data  = 8'h55;
    in_valid = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (in_ready  !== 1'b0) begin errors++; $display("FAIL done_in_ready: got %0b exp 0", in_ready); end
    checks++; if (load_done !== 1'b1) begin errors++; $display("FAIL done_hold: got %0b exp 1", load_done); end
    in_valid = 1'b0;
    pulse_start();
    checks++; if (in_ready  !== 1'b1) begin errors++; $display("FAIL rearm_in_ready: got %0b exp 1", in_ready); end
    checks++; if (load_done !== 1'b0) begin errors++; $display("FAIL rearm_done: got %0b exp 0", load_done); end
    checks++; if (cpu_hold  !== 1'b1) begin errors++; $display("FAIL rearm_cpu_hold: got %0b exp 1", cpu_hold); end
  endtask

  task automatic test_bad_csum();
    int base = wr_cnt;
    send_std_frame(8'h03);
    checks++; if (wr_cnt - base !== 2) begin errors++; $display("FAIL bad_wr_count: got %0d exp 2", wr_cnt - base); end
    checks++; if (wr_data_log[base+1] !== 32'h8C020001) begin errors++; $display("FAIL bad_data1: got %08h exp 8C020001", wr_data_log[base+1]); end
    checks++; if (load_err  !== 1'b1) begin errors++; $display("FAIL bad_err: got %0b exp 1", load_err); end
    checks++; if (cpu_hold  !== 1'b1) begin errors++; $display("FAIL bad_cpu_hold: got %0b exp 1", cpu_hold); end
    checks++; if (load_done !== 1'b0) begin errors++; $display("FAIL bad_done: got %0b exp 0", load_done); end
    pulse_start();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bad_rearm_ready: got %0b exp 1", in_ready); end
    checks++; if (load_err !== 1'b0) begin errors++; $display("FAIL bad_rearm_err: got %0b exp 0", load_err); end
  endtask

  task automatic test_oversize();
    int base = wr_cnt;
    logic [7:0] x = 8'h00;
    send_byte(8'h0B);
    checks++; if (load_err !== 1'b1) begin errors++; $display("FAIL over_err: got %0b exp 1", load_err); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL over_in_ready: got %0b exp 0", in_ready); end
    checks++; if (wr_cnt - base !== 0) begin errors++; $display("FAIL over_no_write: got %0d writes exp 0", wr_cnt - base); end
    pulse_start();
    // Full-capacity frame: data bytes 0x00..0x27.
    base = wr_cnt;
    send_byte(8'h0A);
    for (int k = 0; k < 40; k++) begin
      send_byte(8'(k));
      x = x ^ 8'(k);
    end
    send_byte(x);
    checks++; if (wr_cnt - base !== 10) begin errors++; $display("FAIL max_wr_count: got %0d exp 10", wr_cnt - base); end
    checks++; if (wr_addr_log[base+9] !== 32'h24) begin errors++; $display("FAIL max_last_addr: got %08h exp 00000024", wr_addr_log[base+9]); end
    checks++; if (wr_data_log[base+9] !== 32'h24252627) begin errors++; $display("FAIL max_last_data: got %08h exp 24252627", wr_data_log[base+9]); end
    checks++; if (wr_data_log[base] !== 32'h00010203) begin errors++; $display("FAIL max_first_data: got %08h exp 00010203", wr_data_log[base]); end
    checks++; if (load_done !== 1'b1) begin errors++; $display("FAIL max_done: got %0b exp 1", load_done); end
    pulse_start();
  endtask

  task automatic test_empty();
    int base = wr_cnt;
    send_byte(8'h00);
    send_byte(8'h00);
    checks++; if (load_done !== 1'b1) begin errors++; $display("FAIL empty_done: got %0b exp 1", load_done); end
    checks++; if (wr_cnt - base !== 0) begin errors++; $display("FAIL empty_no_write: got %0d writes exp 0", wr_cnt - base); end
    pulse_start();
    send_byte(8'h00);
    send_byte(8'h01);
    checks++; if (load_err !== 1'b1) begin errors++; $display("FAIL empty_bad_err: got %0b exp 1", load_err); end
    checks++; if (load_done !== 1'b0) begin errors++; $display("FAIL empty_bad_done: got %0b exp 0", load_done); end
    pulse_start();
  endtask

  task automatic test_back_to_back();
    logic [7:0] f    [10] = '{8'h02, 8'h8C, 8'h01, 8'h00, 8'h00,
                              8'h8C, 8'h02, 8'h00, 8'h01, 8'h02};
    int         gaps [10] = '{1, 0, 2, 3, 0, 1, 0, 2, 4, 1};
    int base = wr_cnt;
    for (int i = 0; i < 10; i++) begin
      repeat (gaps[i]) @(negedge clk);
      if (i == 3 || i == 5 || i == 9) pulse_start();
      send_byte(f[i]);
    end
    checks++; if (wr_cnt - base !== 2) begin errors++; $display("FAIL stall_wr_count: got %0d exp 2", wr_cnt - base); end
    checks++; if (wr_addr_log[base] !== 32'h0 || wr_data_log[base] !== 32'h8C010000) begin errors++; $display("FAIL stall_w0: got %08h/%08h exp 00000000/8C010000", wr_addr_log[base], wr_data_log[base]); end
    checks++; if (wr_addr_log[base+1] !== 32'h4 || wr_data_log[base+1] !== 32'h8C020001) begin errors++; $display("FAIL stall_w1: got %08h/%08h exp 00000004/8C020001", wr_addr_log[base+1], wr_data_log[base+1]); end
    checks++; if (load_done !== 1'b1) begin errors++; $display("FAIL stall_done: got %0b exp 1", load_done); end
    pulse_start();
  endtask

  task automatic test_reset_midframe();
    logic [7:0] f [7] = '{8'h02, 8'h8C, 8'h01, 8'h00, 8'h00, 8'h8C, 8'h02};
    int base = wr_cnt;
    for (int i = 0; i < 7; i++) send_byte(f[i]);
    #2 reset = 1'b0;
    #1;
    checks++; if (in_ready  !== 1'b0)  begin errors++; $display("FAIL mrst_in_ready: got %0b exp 0", in_ready); end
    checks++; if (wr_en     !== 1'b0)  begin errors++; $display("FAIL mrst_wr_en: got %0b exp 0", wr_en); end
    checks++; if (wr_addr   !== 32'h0) begin errors++; $display("FAIL mrst_wr_addr: got %08h exp 0", wr_addr); end
    checks++; if (wr_data   !== 32'h0) begin errors++; $display("FAIL mrst_wr_data: got %08h exp 0", wr_data); end
    checks++; if (cpu_hold  !== 1'b1)  begin errors++; $display("FAIL mrst_cpu_hold: got %0b exp 1", cpu_hold); end
    checks++; if (load_done !== 1'b0 || load_err !== 1'b0) begin errors++; $display("FAIL mrst_flags: got done=%0b err=%0b exp 0/0", load_done, load_err); end
    repeat (3) @(negedge clk);
    checks++; if (wr_cnt - base !== 1) begin errors++; $display("FAIL mrst_wr_count: got %0d exp 1", wr_cnt - base); end
    reset = 1'b1;
    base = wr_cnt;
    send_std_frame(8'h02);
    checks++; if (wr_cnt - base !== 2) begin errors++; $display("FAIL post_wr_count: got %0d exp 2", wr_cnt - base); end
    checks++; if (wr_addr_log[base] !== 32'h0 || wr_data_log[base] !== 32'h8C010000) begin errors++; $display("FAIL post_w0: got %08h/%08h exp 00000000/8C010000", wr_addr_log[base], wr_data_log[base]); end
    checks++; if (wr_addr_log[base+1] !== 32'h4 || wr_data_log[base+1] !== 32'h8C020001) begin errors++; $display("FAIL post_w1: got %08h/%08h exp 00000004/8C020001", wr_addr_log[base+1], wr_data_log[base+1]); end
    checks++; if (load_done !== 1'b1 || cpu_hold !== 1'b0) begin errors++; $display("FAIL post_done: got done=%0b hold=%0b exp 1/0", load_done, cpu_hold); end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_bad_csum();
    test_oversize();
    test_empty();
    test_back_to_back();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
